// File: rtl/turbidity_adc_responder.sv
// Enable/ready acquisition responder for the turbidity sensor: reads an MCP3201-style
// SPI ADC 2^LOG2_AVG times per request and presents the truncated average.
`timescale 1ns/1ps
module turbidity_adc_responder #(
  parameter int CLK_DIV    = 16,
  parameter int LOG2_AVG   = 2,
  parameter int GAP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        ready,
  output logic [11:0] turbidez,
  output logic        adc_fault,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_miso
);

  localparam int DATA_W = 12;
  localparam int DIV_W  = 8;
  localparam int TOG_W  = 5;
  localparam int GAP_W  = 10;
  localparam int CNT_W  = LOG2_AVG + 1;
  localparam int ACC_W  = DATA_W + LOG2_AVG;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_AVG    = CNT_W'(1 << LOG2_AVG);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TOG_W-1:0]    tog_q, tog_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W:0]     sh_q, sh_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   turb_q, turb_d;
  logic                fault_q, fault_d;
  logic                miso_p0_q, miso_p1_q;

  logic                div_tc;
  logic                last_tog;
  logic                abort;
  logic [CNT_W-1:0]    cnt_inc;

  // Average by keeping the top DATA_W bits of the accumulator (truncating divide).
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1 -: DATA_W];
  endfunction

  assign div_tc   = (div_q == DIV_LAST);
  assign last_tog = div_tc && (tog_q == TOG_W'(31));
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign abort    = !enable && (state_q == SETUP || state_q == SHIFT ||
                                state_q == GAP   || state_q == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tog_q     <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ready_q   <= 1'b0;
      turb_q    <= '0;
      fault_q   <= 1'b0;
      miso_p0_q <= 1'b0;
      miso_p1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tog_q     <= tog_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      ready_q   <= ready_d;
      turb_q    <= turb_d;
      fault_q   <= fault_d;
      miso_p0_q <= adc_miso;
      miso_p1_q <= miso_p0_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = SETUP;
      SETUP: if (!enable) state_d = IDLE;
             else if (div_tc) state_d = SHIFT;
      SHIFT: if (!enable) state_d = IDLE;
             else if (last_tog) state_d = (cnt_inc == N_AVG) ? DONE : GAP;
      GAP:   if (!enable) state_d = IDLE;
             else if (gap_q == GAP_LAST) state_d = SETUP;
      DONE:  state_d = enable ? HOLD : IDLE;
      HOLD:  if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    tog_d   = tog_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    ready_d = ready_q;
    turb_d  = turb_q;
    fault_d = fault_q;
    if (abort) begin
      cs_n_d = 1'b1;
      sclk_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          cs_n_d  = 1'b0;
          fault_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          div_d   = '0;
        end
        SETUP: begin
          div_d = div_tc ? '0 : div_q + DIV_W'(1);
          tog_d = '0;
        end
        SHIFT: begin
          div_d = div_tc ? '0 : div_q + DIV_W'(1);
          if (div_tc) begin
            sclk_d = ~sclk_q;
            tog_d  = tog_q + TOG_W'(1);
            // Rising edges 1..15 carry b0..b14; b0/b1 fall off the top, b15 is never kept.
            if (!sclk_q && tog_q != TOG_W'(30))
              sh_d = {sh_q[DATA_W-1:0], miso_p1_q};
            if (tog_q == TOG_W'(31)) begin
              cs_n_d = 1'b1;
              acc_d  = acc_q + ACC_W'(sh_q[DATA_W-1:0]);
              cnt_d  = cnt_inc;
              gap_d  = '0;
              if (sh_q[DATA_W]) fault_d = 1'b1;
            end
          end
        end
        GAP: begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_q == GAP_LAST) begin
            cs_n_d = 1'b0;
            div_d  = '0;
          end
        end
        DONE: begin
          turb_d  = avg_trunc(acc_q);
          ready_d = 1'b1;
        end
        HOLD: if (!enable) ready_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign ready     = ready_q;
  assign turbidez  = turb_q;
  assign adc_fault = fault_q;
  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;

endmodule

// File: tb/tb_turbidity_adc_responder.sv
// Scoreboarded bench for turbidity_adc_responder with behavioural MCP3201-style ADC models.
`timescale 1ns/1ps
module tb_turbidity_adc_responder;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        reset, enable, ready, adc_fault, adc_cs_n, adc_sclk, adc_miso;
  logic [11:0] turbidez;
  logic        enable6, ready6, fault6, cs6, sclk6, miso6;
  logic [11:0] turb6;

  turbidity_adc_responder u_dut (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready), .turbidez(turbidez),
    .adc_fault(adc_fault), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_miso(adc_miso));

  turbidity_adc_responder #(.CLK_DIV(2), .LOG2_AVG(0), .GAP_CYCLES(1)) u_dut6 (
    .clk(clk), .reset(reset), .enable(enable6), .ready(ready6), .turbidez(turb6),
    .adc_fault(fault6), .adc_cs_n(cs6), .adc_sclk(sclk6), .adc_miso(miso6));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // ADC model for the default instance: data changes after each SCLK rise.
  logic [11:0] adc_data = 12'h000;
  logic        stuck = 1'b0;
  logic [11:0] frame_vals[$];
  logic [15:0] word = 16'h0000;
  logic [3:0]  bidx = 4'd15;
  int          rise_cnt = 0;
  int          frames_cnt = 0;
  int          rises_q[$];
  assign adc_miso = word[bidx];

  always @(negedge adc_cs_n or posedge adc_sclk) begin
    if (adc_sclk) begin
      rise_cnt++;
      check("sclk_rise_cs_low", {31'd0, adc_cs_n}, 32'd0);
      if (bidx != 4'd0) bidx--;
    end else begin
      logic [11:0] v;
      v = adc_data;
      if (frame_vals.size() > 0) v = frame_vals.pop_front();
      word = stuck ? 16'hFFFF : {2'b00, 1'b0, v, ~v[0]};
      bidx = 4'd15;
      rise_cnt = 0;
    end
  end

  always @(posedge adc_cs_n) begin
    rises_q.push_back(rise_cnt);
    frames_cnt++;
  end

  logic [11:0] adc6_data = 12'hABC;
  logic [15:0] word6 = 16'h0000;
  logic [3:0]  bidx6 = 4'd15;
  assign miso6 = word6[bidx6];

  always @(negedge cs6 or posedge sclk6) begin
    if (sclk6) begin
      check("sclk6_rise_cs_low", {31'd0, cs6}, 32'd0);
      if (bidx6 != 4'd0) bidx6--;
    end else begin
      word6 = {3'b000, adc6_data, ~adc6_data[0]};
      bidx6 = 4'd15;
    end
  end

  typedef struct {
    logic [11:0] turb;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [11:0] t, input logic f, input int l);
    exp_t e;
    e.turb = t; e.fault = f; e.lat = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every ready rise must match the next queued expectation.
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {31'd0, ready}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_turbidez", {20'd0, turbidez}, {20'd0, e.turb});
        check("sb_fault", {31'd0, adc_fault}, {31'd0, e.fault});
        check("sb_latency", cyc - e0, e.lat);
      end
    end
    ready_prev <= ready;
  end

  task automatic start_req();
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    check("cs_low_at_e0", {31'd0, adc_cs_n}, 32'd0);
    check("fault_clear_at_e0", {31'd0, adc_fault}, 32'd0);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready_seen"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic drop_req(input string nm, input logic [11:0] t);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check({nm, "_ready_drop"}, {31'd0, ready}, 32'd0);
    check({nm, "_turb_kept"}, {20'd0, turbidez}, {20'd0, t});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int fs;
    reset = 1'b1; enable = 1'b0; enable6 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_turbidez", {20'd0, turbidez}, 32'd0);
    check("rst_fault", {31'd0, adc_fault}, 32'd0);
    check("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, adc_sclk}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: constant 0x800, four complete frames
    rises_q.delete();
    adc_data = 12'h800;
    push_exp(12'h800, 1'b0, 2305);
    start_req();
    wait_ready("t1");
    check("t1_frames", rises_q.size(), 4);
    foreach (rises_q[i]) check("t1_rises_per_frame", rises_q[i], 16);
    drop_req("t1", 12'h800);

    // 2: 1+2+3+5 = 11, >>2 = 2
    frame_vals = '{12'h001, 12'h002, 12'h003, 12'h005};
    push_exp(12'h002, 1'b0, 2305);
    start_req();
    wait_ready("t2");
    repeat (50) @(negedge clk);
    check("t2_hold_ready", {31'd0, ready}, 32'd1);
    check("t2_hold_turb", {20'd0, turbidez}, 32'h002);
    drop_req("t2", 12'h002);

    // 3: miso stuck high, then healthy 0x100
    stuck = 1'b1;
    push_exp(12'hFFF, 1'b1, 2305);
    start_req();
    wait_ready("t3a");
    drop_req("t3a", 12'hFFF);
    check("t3_fault_sticky", {31'd0, adc_fault}, 32'd1);
    stuck = 1'b0;
    adc_data = 12'h100;
    push_exp(12'h100, 1'b0, 2305);
    start_req();
    wait_ready("t3b");
    drop_req("t3b", 12'h100);

    // 4: abort after the 7th rise of frame 2, then full restart
    adc_data = 12'h123;
    fs = frames_cnt;
    start_req();
    n = 0;
    while (!(frames_cnt == fs + 1 && rise_cnt == 7) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_rise7", rise_cnt, 7);
    enable = 1'b0;
    @(negedge clk);
    check("t4_abort_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("t4_abort_sclk", {31'd0, adc_sclk}, 32'd0);
    check("t4_abort_turb", {20'd0, turbidez}, 32'h100);
    repeat (100) @(negedge clk);
    check("t4_no_ready", {31'd0, ready}, 32'd0);
    check("t4_cs_idle", {31'd0, adc_cs_n}, 32'd1);
    push_exp(12'h123, 1'b0, 2305);
    start_req();
    wait_ready("t4");
    drop_req("t4", 12'h123);

    // 5: asynchronous reset mid-SHIFT
    adc_data = 12'h456;
    fs = frames_cnt;
    start_req();
    n = 0;
    while (!(frames_cnt == fs && rise_cnt == 3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_rise3", rise_cnt, 3);
    reset = 1'b1;
    #1;
    check("t5_rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check("t5_rst_sclk", {31'd0, adc_sclk}, 32'd0);
    check("t5_rst_ready", {31'd0, ready}, 32'd0);
    check("t5_rst_turb", {20'd0, turbidez}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(12'h456, 1'b0, 2305);
    start_req();
    wait_ready("t5");
    drop_req("t5", 12'h456);

    // 6: single conversion with minimum divider and gap
    @(negedge clk);
    enable6 = 1'b1;
    fs = cyc + 1;
    n = 0;
    while (!ready6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_ready", {31'd0, ready6}, 32'd1);
    check("t6_latency", cyc - fs, 67);
    check("t6_turb", {20'd0, turb6}, 32'hABC);
    check("t6_fault", {31'd0, fault6}, 32'd0);
    enable6 = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_ready_drop", {31'd0, ready6}, 32'd0);

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turbidity_adc_responder.md
Name: turbidity_adc_responder

Overview:
- Sensor-side responder for the irrigation controller's enable/ready acquisition handshake.
- On a level-high enable request, it reads a 12-bit SPI ADC (MCP3201-style) attached to the turbidity sensor and averages 2^LOG2_AVG conversions.
- It then presents the 12-bit result with a held ready flag until the requester drops enable.
- It replaces the external ESP32 path and feeds the valve controller's turbidity input directly.

Parameters:
CLK_DIV, 16, clk cycles per SCLK half-period (25 MHz / 32 = 781 kHz SCLK); legal range 2..255
LOG2_AVG, 2, log2 of conversions averaged per request (default 4); legal range 0..4
GAP_CYCLES, 64, minimum cs_n-high cycles between consecutive conversions; legal range 1..1023

Ports:
clk  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  acquisition request, level; held high by the requester until it sees ready
ready  out  1  result valid; held high while enable stays high after completion
turbidez  out  12  averaged ADC result; stable whenever ready=1
adc_fault  out  1  null-bit error seen during the current or last request
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  ADC serial clock, idle low
adc_miso  in  1  ADC serial data; synchronised by a 2-flop stage before use

Behaviour:
- Reset values: ready=0, turbidez=0, adc_fault=0, adc_cs_n=1, adc_sclk=0. Accumulator, counters and state are cleared; state=IDLE.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, GAP, DONE, HOLD.
- IDLE:
  - On the edge E0 where enable=1 is sampled: adc_cs_n<=0, adc_fault<=0, accumulator<=0, sample count<=0, go to SETUP.
- SETUP:
  - Lasts CLK_DIV cycles with adc_sclk=0, then go to SHIFT.
- SHIFT:
  - A divider counts 0..CLK_DIV-1; adc_sclk toggles at each terminal count, giving 32 toggles (16 SCLK periods).
  - On the edge where adc_sclk goes 0->1, the synchronised miso is shifted in as bit b0..b15, MSB first.
  - Result = b3..b14 (b3 is MSB); b0, b1 and b15 are ignored.
  - If b2 (null bit) = 1, set adc_fault=1 (sticky until the next request); the sample is still accumulated.
  - On the 32nd toggle (sclk back to 0), set adc_cs_n<=1 on the same edge and add the 12-bit result to a (12+LOG2_AVG)-bit accumulator, which cannot overflow.
  - Increment the sample count. If count = 2^LOG2_AVG go to DONE, else go to GAP.
- GAP:
  - adc_cs_n=1 for GAP_CYCLES cycles, then adc_cs_n<=0 and go to SETUP.
- DONE (one cycle):
  - turbidez <= accumulator >> LOG2_AVG (truncating), ready<=1, go to HOLD.
- HOLD:
  - ready=1 and turbidez is held while enable=1.
  - When enable=0 is sampled: ready<=0 on that edge and go to IDLE. turbidez keeps its last value.
- Latency: ready rises at E0 + 2^LOG2_AVG*33*CLK_DIV + (2^LOG2_AVG-1)*GAP_CYCLES + 1 cycles. Defaults give 2305 cycles.
- Abort: if enable=0 is sampled in SETUP, SHIFT, GAP or DONE:
  - Next edge: adc_cs_n=1, adc_sclk=0, ready stays 0, state=IDLE.
  - turbidez and adc_fault are unchanged; partial results are discarded.
- Re-request: enable must be sampled low for at least one cycle, returning the block to IDLE, before a new acquisition starts. Holding enable high through HOLD never retriggers a conversion.
- Reset asserted mid-frame: immediately return all outputs to reset values; adc_cs_n goes high asynchronously.
- adc_sclk never toggles while adc_cs_n=1.

Test Plan:
1. Defaults, ADC model returns 0x800 every frame, null bit 0, enable held high -> ready rises exactly 2305 cycles after E0, turbidez=0x800, adc_fault=0, four cs_n-low frames each with 16 SCLK rising edges.
2. ADC returns 0x001, 0x002, 0x003, 0x005 -> sum 11, turbidez=0x002 (truncated), ready holds until enable drops, then ready=0 one edge later with turbidez still 0x002.
3. miso stuck high (null bit 1, data 0xFFF) -> turbidez=0xFFF, adc_fault=1; next request with a healthy ADC returning 0x100 -> adc_fault clears at E0 and final turbidez=0x100.
4. enable dropped after the 7th SCLK rise of the 2nd frame -> cs_n=1 and sclk=0 on the next edge, ready never asserts, turbidez keeps the previous value; re-raising enable restarts from frame 1 with full latency.
5. reset pulsed during SHIFT -> cs_n=1, sclk=0, ready=0, turbidez=0 immediately; the first post-reset request completes normally.
6. LOG2_AVG=0, CLK_DIV=2, GAP_CYCLES=1, ADC returns 0xABC -> ready at E0+67, turbidez=0xABC.
